time_of_day_counter: RTL and testbench
======================================

# time_of_day_counter

Time-of-day counter fed by the divided-clock outputs of the clock generator. It counts seconds, minutes and hours in BCD from the 1 Hz output and provides a set mode: while set is active, held increment buttons auto-repeat at the 5 Hz output. All logic runs on the 50 MHz system clock. The divided clocks are used only as sampled level inputs with edge detection, never as clocks. Outputs drive the display multiplexer downstream.

## Interface
- MODE_24H, 1: 1 selects a 24 h count (00..23); 0 selects a 12 h count (12, 01..11) with the `pm` flag.
- clk  in  1  50 MHz system clock; all flops on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- clock_1Hz  in  1  1 Hz square wave from the clock generator; same clock domain.
- clock_5Hz  in  1  5 Hz square wave from the clock generator; same clock domain.
- set_mode  in  1  set-mode button level; asynchronous, already debounced.
- inc_minutes  in  1  minute-advance button; asynchronous, already debounced.
- inc_hours  in  1  hour-advance button; asynchronous, already debounced.
- hours_bcd  out  8  [7:4] tens, [3:0] units.
- minutes_bcd  out  8  [7:4] tens (0..5), [3:0] units.
- seconds_bcd  out  8  [7:4] tens (0..5), [3:0] units.
- pm  out  1  12 h mode only; constant 0 when MODE_24H=1.
- tick_1s  out  1  one-clk pulse on every accepted seconds increment.
- day_rollover  out  1  one-clk pulse when the count wraps 23:59:59→00:00:00 (24 h) or 11:59:59 pm→12:00:00 am (12 h).

## Operation
- Reset values:
  - 24 h mode: 00:00:00.
  - 12 h mode: 12:00:00, pm=0.
  - tick_1s=0, day_rollover=0.
- Edge detection: clock_1Hz and clock_5Hz are each registered once. The rising-edge strobe is in & ~in_q, registered, giving tick1 and tick5.
- Buttons: each passes through a 2-FF synchronizer. Internal levels are set_s, incm_s and inch_s.
- Normal mode (set_s=0), on tick1:
  - Seconds +1.
  - 59→00 carries into minutes; minutes 59→00 carries into hours.
  - Hours wrap 23→00 in 24 h mode.
  - In 12 h mode, hours run 11→12 and toggle pm; 12→01 does not toggle pm. day_rollover fires when pm toggles 1→0.
- Entering set mode (set_s rising) forces seconds to 00 on the next clk. tick1 is then ignored and tick_1s stays 0.
- In set mode, on tick5:
  - If incm_s=1, minutes +1 with a 59→00 wrap and no carry into hours.
  - If inch_s=1, hours +1 with the mode wrap; pm toggles as in normal mode but day_rollover is not asserted.
  - Both buttons may advance on the same tick5.
- Leaving set mode resumes counting at the next tick1, from seconds 00.
- BCD digits never take values above their legal maximum. Each digit is a separate counter, not a binary-to-BCD conversion.

## Timing
- Latency from clock_1Hz rising at the input to the counter update is 3 clk:
  - one edge to register the input,
  - one edge to register tick1,
  - one edge to update the counter.
- tick_1s and day_rollover are asserted in the same cycle the new count is first visible.
- Button latency is 2 clk for the synchronizer, plus the wait for the next tick5 (≤200 ms).
- If tick1 and a set_s change occur in the same cycle, set_s wins:
  - set_s rising: the tick is dropped and seconds clear.
  - set_s falling: the tick is dropped and counting resumes at the following tick1.
- Outputs are registered and glitch-free; all counter fields change in the same clk edge.
- When reset_n is asserted mid-count, all outputs go immediately (asynchronously) to their reset values. The first tick1 after release is counted only if its input edge arrives at least 2 clk after release.

## Test plan
- Reset then 61 rising edges on clock_1Hz → 00:01:01. tick_1s is pulsed exactly 61 times, each 1 clk wide, 3 clk after each input edge.
- Preload by counting to 23:59:58 (24 h), then 2 edges → 23:59:59, then 00:00:00 with day_rollover=1 for exactly 1 clk.
- MODE_24H=0: count from 11:59:59 pm=0 → 12:00:00 pm=1, day_rollover=0. From 11:59:59 pm=1 → 12:00:00 pm=0, day_rollover=1.
- In set mode at 10:58:00, hold inc_minutes for 3 tick5 edges → 10:01:00, hours unchanged.
- Assert set_mode at 07:15:42 → seconds 00. Five clock_1Hz edges give no change and no tick_1s. Release → next tick1 gives 07:15:01.
- Pulse reset_n low mid-count at 13:27:09 → 00:00:00 within the same cycle. Reset clk-synchronous clock_1Hz edges 1 and 4 clk after release → only the second is counted.

Source files
------------

// File: rtl/time_of_day_counter.sv
// time_of_day_counter: BCD hh:mm:ss clock with set mode, advanced by sampled 1 Hz / 5 Hz strobes.
module time_of_day_counter #(
  parameter bit MODE_24H = 1'b1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clock_1Hz,
  input  logic       clock_5Hz,
  input  logic       set_mode,
  input  logic       inc_minutes,
  input  logic       inc_hours,
  output logic [7:0] hours_bcd,
  output logic [7:0] minutes_bcd,
  output logic [7:0] seconds_bcd,
  output logic       pm,
  output logic       tick_1s,
  output logic       day_rollover
);
  localparam logic [7:0] HOUR_RST = MODE_24H ? 8'h00 : 8'h12;
  logic [2:0] rst_pipe;
  logic [1:0] set_y, incm_y, inch_y;
  logic       c1_r, c1_q, c5_r, c5_q, tick1, tick5, set_q;
  logic       set_s, incm_s, inch_s, enter, run, adj;
  logic       sec_wrap, min_wrap, min_step, hr_step, pm_flip, last_hour;
  logic [7:0] hr_next;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    return v[3:0] == 4'd9 ? {v[7:4] + 4'd1, 4'd0} : {v[7:4], v[3:0] + 4'd1};
  endfunction

  always_comb begin
    set_s     = set_y[1];
    incm_s    = incm_y[1];
    inch_s    = inch_y[1];
    enter     = set_s & ~set_q;
    run       = ~set_s & ~set_q & tick1;
    adj       = set_s & set_q & tick5;
    sec_wrap  = seconds_bcd == 8'h59;
    min_wrap  = minutes_bcd == 8'h59;
    min_step  = run ? sec_wrap : adj & incm_s;
    hr_step   = run ? sec_wrap & min_wrap : adj & inch_s;
    pm_flip   = !MODE_24H && hours_bcd == 8'h11;
    last_hour = MODE_24H ? hours_bcd == 8'h23 : pm && hours_bcd == 8'h11;
    hr_next   = (MODE_24H && hours_bcd == 8'h23) ? 8'h00 :
                (!MODE_24H && hours_bcd == 8'h12) ? 8'h01 : bcd_inc(hours_bcd);
  end

  // strobes stay masked until reset release has propagated through rst_pipe
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rst_pipe     <= '0;
      c1_r         <= 1'b0;
      c1_q         <= 1'b0;
      c5_r         <= 1'b0;
      c5_q         <= 1'b0;
      tick1        <= 1'b0;
      tick5        <= 1'b0;
      set_y        <= '0;
      incm_y       <= '0;
      inch_y       <= '0;
      set_q        <= 1'b0;
      hours_bcd    <= HOUR_RST;
      minutes_bcd  <= '0;
      seconds_bcd  <= '0;
      pm           <= 1'b0;
      tick_1s      <= 1'b0;
      day_rollover <= 1'b0;
    end else begin
      rst_pipe     <= {rst_pipe[1:0], 1'b1};
      c1_r         <= clock_1Hz;
      c1_q         <= c1_r;
      c5_r         <= clock_5Hz;
      c5_q         <= c5_r;
      tick1        <= rst_pipe[2] & c1_r & ~c1_q;
      tick5        <= rst_pipe[2] & c5_r & ~c5_q;
      set_y        <= {set_y[0], set_mode};
      incm_y       <= {incm_y[0], inc_minutes};
      inch_y       <= {inch_y[0], inc_hours};
      set_q        <= set_s;
      tick_1s      <= run;
      day_rollover <= run & sec_wrap & min_wrap & last_hour;
      if (enter) seconds_bcd <= '0;
      else if (run) seconds_bcd <= sec_wrap ? 8'h00 : bcd_inc(seconds_bcd);
      if (min_step) minutes_bcd <= min_wrap ? 8'h00 : bcd_inc(minutes_bcd);
      if (hr_step) hours_bcd <= hr_next;
      if (hr_step && pm_flip) pm <= ~pm;
    end
  end
endmodule

// File: tb/tb_time_of_day_counter.sv
// tb_time_of_day_counter: directed test of 24 h and 12 h instances driven by shared stimulus.
module tb_time_of_day_counter;
  logic clk = 0, reset_n = 0, clock_1Hz = 0, clock_5Hz = 0;
  logic set_mode = 0, inc_minutes = 0, inc_hours = 0;
  logic [7:0] h24, m24, s24, h12, m12, s12;
  logic pm24, pm12, t24, t12, r24, r12;
  int n_chk = 0, n_err = 0, n_t24 = 0, n_t12 = 0, n_r24 = 0, n_r12 = 0, t0;

  always #5 clk = ~clk;

  time_of_day_counter #(.MODE_24H(1'b1)) d24 (
    .clk(clk), .reset_n(reset_n), .clock_1Hz(clock_1Hz), .clock_5Hz(clock_5Hz),
    .set_mode(set_mode), .inc_minutes(inc_minutes), .inc_hours(inc_hours),
    .hours_bcd(h24), .minutes_bcd(m24), .seconds_bcd(s24), .pm(pm24),
    .tick_1s(t24), .day_rollover(r24));

  time_of_day_counter #(.MODE_24H(1'b0)) d12 (
    .clk(clk), .reset_n(reset_n), .clock_1Hz(clock_1Hz), .clock_5Hz(clock_5Hz),
    .set_mode(set_mode), .inc_minutes(inc_minutes), .inc_hours(inc_hours),
    .hours_bcd(h12), .minutes_bcd(m12), .seconds_bcd(s12), .pm(pm12),
    .tick_1s(t12), .day_rollover(r12));

  always @(negedge clk) begin
    n_t24 <= n_t24 + int'(t24);
    n_t12 <= n_t12 + int'(t12);
    n_r24 <= n_r24 + int'(r24);
    n_r12 <= n_r12 + int'(r12);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk24(input string tag, input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    check({tag, "_24"}, {7'd0, pm24, h24, m24, s24}, {8'd0, h, m, s});
  endtask

  task automatic chk12(input string tag, input logic p, input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    check({tag, "_12"}, {7'd0, pm12, h12, m12, s12}, {7'd0, p, h, m, s});
  endtask

  task automatic sec_edge(input bit chk);
    @(negedge clk) clock_1Hz = 1;
    @(negedge clk) clock_1Hz = 0;
    @(negedge clk) if (chk) check("tick_early", 32'(t24), 0);
    @(negedge clk) if (chk) check("tick_at_3clk", 32'(t24), 1);
    @(negedge clk) if (chk) check("tick_width", 32'(t24), 0);
  endtask

  task automatic five_edge();
    @(negedge clk) clock_5Hz = 1;
    @(negedge clk) clock_5Hz = 0;
    repeat (2) @(negedge clk);
  endtask

  task automatic adjust(input int nh, input int nm);
    for (int i = 0; i < (nh > nm ? nh : nm); i++) begin
      @(negedge clk);
      inc_hours = i < nh;
      inc_minutes = i < nm;
      five_edge();
    end
    @(negedge clk);
    inc_hours = 0;
    inc_minutes = 0;
    repeat (3) @(negedge clk);
  endtask

  task automatic set_level(input logic v);
    @(negedge clk) set_mode = v;
    repeat (4) @(negedge clk);
  endtask

  task automatic preload(input int nh, input int nm, input int ns);
    set_level(1);
    adjust(nh, nm);
    set_level(0);
    repeat (ns) sec_edge(0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk24("reset", 8'h00, 8'h00, 8'h00);
    chk12("reset", 1'b0, 8'h12, 8'h00, 8'h00);
    check("reset_flags", {t24, r24, t12, r12}, 0);
    @(negedge clk) reset_n = 1;
    repeat (4) @(negedge clk);

    repeat (61) sec_edge(1);
    chk24("count61", 8'h00, 8'h01, 8'h01);
    chk12("count61", 1'b0, 8'h12, 8'h01, 8'h01);
    check("tick_count", n_t24, 61);

    preload(23, 58, 58);
    chk24("preload", 8'h23, 8'h59, 8'h58);
    chk12("preload", 1'b1, 8'h11, 8'h59, 8'h58);
    check("no_roll_in_set", n_r12, 0);
    sec_edge(0);
    chk24("last_sec", 8'h23, 8'h59, 8'h59);
    sec_edge(0);
    chk24("day_wrap", 8'h00, 8'h00, 8'h00);
    chk12("pm_to_am", 1'b0, 8'h12, 8'h00, 8'h00);
    check("rollover24", n_r24, 1);
    check("rollover12", n_r12, 1);

    preload(11, 59, 59);
    chk12("am_1159", 1'b0, 8'h11, 8'h59, 8'h59);
    sec_edge(0);
    chk12("am_to_pm", 1'b1, 8'h12, 8'h00, 8'h00);
    chk24("noon", 8'h12, 8'h00, 8'h00);
    check("no_roll_noon24", n_r24, 1);
    check("no_roll_noon12", n_r12, 1);

    set_level(1);
    adjust(22, 58);
    chk24("set_1058", 8'h10, 8'h58, 8'h00);
    chk12("set_1058", 1'b0, 8'h10, 8'h58, 8'h00);
    adjust(0, 3);
    chk24("min_wrap", 8'h10, 8'h01, 8'h00);
    chk12("min_wrap", 1'b0, 8'h10, 8'h01, 8'h00);
    check("no_roll_set12", n_r12, 1);

    adjust(21, 14);
    set_level(0);
    repeat (42) sec_edge(0);
    chk24("at_071542", 8'h07, 8'h15, 8'h42);
    chk12("at_071542", 1'b0, 8'h07, 8'h15, 8'h42);
    set_level(1);
    chk24("set_clears_sec", 8'h07, 8'h15, 8'h00);
    t0 = n_t24;
    repeat (5) sec_edge(0);
    check("no_tick_in_set", n_t24, t0);
    chk24("frozen_in_set", 8'h07, 8'h15, 8'h00);
    set_level(0);
    sec_edge(1);
    chk24("resume", 8'h07, 8'h15, 8'h01);

    preload(6, 12, 9);
    chk24("at_132709", 8'h13, 8'h27, 8'h09);
    chk12("at_132709", 1'b1, 8'h01, 8'h27, 8'h09);
    @(negedge clk);
    #2 reset_n = 0;
    #1;
    chk24("async_reset", 8'h00, 8'h00, 8'h00);
    chk12("async_reset", 1'b0, 8'h12, 8'h00, 8'h00);
    t0 = n_t24;
    @(negedge clk) reset_n = 1;
    @(negedge clk) clock_1Hz = 1;
    @(negedge clk) clock_1Hz = 0;
    @(negedge clk);
    @(negedge clk) clock_1Hz = 1;
    @(negedge clk) clock_1Hz = 0;
    repeat (4) @(negedge clk);
    chk24("post_release", 8'h00, 8'h00, 8'h01);
    check("post_release_ticks", n_t24 - t0, 1);
    check("tick12_matches", n_t12, n_t24);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
